// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the instruction-fetch responder.
//   NOP           : instruction word returned for faulting fetches.
//   fetch_resp_t  : payload carried through the read pipeline and FIFO.
//   is_fault()    : misalignment / out-of-range check on a byte address.
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } fetch_resp_t;

    // A fetch faults when it is not word aligned or when its word index does
    // not fit in addrBits bits. High address bits are never dropped, so an
    // out-of-range address can't alias onto a real word.
    function automatic logic is_fault(input logic [31:0] addr, input int addrBits);
        logic [29:0] wordIdx;
        wordIdx = addr[31:2];
        return (addr[1:0] != 2'b00) || ((wordIdx >> addrBits) != 30'd0);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// ---------------------------------------------------------------------------
// resp_fifo
// Synchronous FIFO of fetch responses. The head entry is presented
// combinationally on dout and stays put until it is popped.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write din at the edge (honoured when not full, or when a
//                  pop happens in the same cycle)
//   pop          : drop the head entry at the edge (ignored when empty)
//   dout         : head entry
//   empty, full  : occupancy flags
// ---------------------------------------------------------------------------
module resp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  fetch_resp_t din,
    output fetch_resp_t dout,
    output logic        empty,
    output logic        full
);

    localparam int PTR_BITS = $clog2(DEPTH);

    // One extra pointer bit tells full apart from empty when the indices match.
    logic [PTR_BITS:0] wrPtr;
    logic [PTR_BITS:0] rdPtr;
    fetch_resp_t       store [DEPTH];
    logic              doPush;
    logic              doPop;

    always_comb begin
        empty  = (wrPtr == rdPtr);
        full   = (wrPtr[PTR_BITS] != rdPtr[PTR_BITS]) &&
                 (wrPtr[PTR_BITS-1:0] == rdPtr[PTR_BITS-1:0]);
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
        dout   = store[rdPtr[PTR_BITS-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (PTR_BITS+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (PTR_BITS+1)'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone
    // decide which entries are meaningful, and unreset arrays map onto RAM.
    always_ff @(posedge clock) begin
        if (doPush) store[wrPtr[PTR_BITS-1:0]] <= din;
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
// Responder side of the DataPath instruction-fetch interface. A fetch request
// carries a byte address; the block reads the word-addressed instruction
// store, carries the result through a fixed-latency pipeline and queues it in
// a response FIFO so the fetch side may stall. Misaligned and out-of-range
// fetches return NOP with resp_fault set. A side-band port loads the image.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake, req_addr = byte address
//   resp_valid/resp_ready : response handshake, resp_instr/resp_fault = payload
//   load_en/addr/data     : word write into the instruction store
// Parameters:
//   ADDR_BITS  : log2 of store depth in 32-bit words
//   LATENCY    : read pipeline depth (1..4)
//   FIFO_DEPTH : response FIFO entries = maximum outstanding requests
// ---------------------------------------------------------------------------
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_instr,
    output logic                 resp_fault,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data
);

    localparam int WORDS    = 2 ** ADDR_BITS;
    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_BITS-1:0] MAX_OUTSTANDING = CNT_BITS'(FIFO_DEPTH);

    logic [31:0]          mem [WORDS];
    logic [CNT_BITS-1:0]  outstanding;
    logic                 accept;
    logic                 respPop;
    logic                 reqFault;
    logic [ADDR_BITS-1:0] reqWord;
    fetch_resp_t          readResp;

    // Stage 0 is the registered memory read taken in the accept cycle;
    // stages 1..LATENCY add the configured delay ahead of the FIFO push, so
    // an accept at edge N shows resp_valid after edge N+LATENCY+1.
    logic [LATENCY:0]     pipeValid;
    fetch_resp_t          pipeData [LATENCY+1];

    fetch_resp_t          fifoHead;
    logic                 fifoEmpty;
    logic                 fifoFull;

    // ---------------------------------------------------------------------
    // Instruction store
    // ---------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments, so a fetch that
    // reads a word in the same cycle it is loaded sees the old contents.
    always_ff @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    // NOTE: every signal of this block gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        reqFault       = is_fault(req_addr, ADDR_BITS);
        reqWord        = req_addr[ADDR_BITS+1:2];
        readResp.fault = reqFault;
        // A faulting address never indexes the store.
        readResp.instr = reqFault ? NOP : mem[reqWord];
    end

    // ---------------------------------------------------------------------
    // Handshakes and credit counter
    // ---------------------------------------------------------------------
    // req_ready depends only on registered state and reset, never on
    // req_valid. Counting every request until its response is popped keeps
    // pipeline + FIFO occupancy within FIFO_DEPTH, so the pipeline never
    // needs to stall.
    assign req_ready  = (outstanding < MAX_OUTSTANDING) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = !fifoEmpty && !reset;
    assign respPop    = resp_valid && resp_ready;
    assign resp_instr = resp_valid ? fifoHead.instr : NOP;
    assign resp_fault = resp_valid && fifoHead.fault;

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, respPop})
                2'b10:   outstanding <= outstanding + CNT_BITS'(1);
                2'b01:   outstanding <= outstanding - CNT_BITS'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Read pipeline: shifts every cycle, only the valids are reset.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pipeValid <= '0;
        end else begin
            pipeValid <= {pipeValid[LATENCY-1:0], accept};
        end
    end

    always_ff @(posedge clock) begin
        pipeData[0] <= readResp;
        for (int i = 1; i <= LATENCY; i++) begin
            pipeData[i] <= pipeData[i-1];
        end
    end

    // ---------------------------------------------------------------------
    // Response FIFO
    // ---------------------------------------------------------------------
    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_respFifo (
        .clock (clock),
        .reset (reset),
        .push  (pipeValid[LATENCY]),
        .pop   (respPop),
        .din   (pipeData[LATENCY]),
        .dout  (fifoHead),
        .empty (fifoEmpty),
        .full  (fifoFull)
    );

    // The credit limit must make a push into a full FIFO impossible.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(pipeValid[LATENCY] && fifoFull && !respPop));
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

    localparam int ADDR_BITS  = 8;
    localparam int LAT        = 2;
    localparam int FIFO_DEPTH = 4;

    logic                 clk;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_instr;
    logic                 resp_fault;
    logic                 load_en;
    logic [ADDR_BITS-1:0] load_addr;
    logic [31:0]          load_data;

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] tbMem [256];
    logic [31:0] img   [4] = '{32'h2008_0005, 32'h2009_0007, 32'h0109_5020, 32'hAC0A_0000};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        string       name;
    } vec_t;

    vec_t vecs [9];

    imem_fetch_responder #(
        .ADDR_BITS  (ADDR_BITS),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_fault (resp_fault),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fillWord(input int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0103);
    endfunction

    // Called just after a falling edge; the load lands on the next rising edge.
    task automatic loadWord(input int idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = ADDR_BITS'(idx);
        load_data = d;
        tbMem[idx] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Bounded wait (in falling edges) for resp_valid; returns edges waited.
    task automatic waitResp(output int waited);
        waited = 0;
        while (!resp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Single fetch from an idle block: checks latency, word and fault flag.
    task automatic fetchOne(input logic [31:0] addr, input logic [31:0] expInstr,
                            input logic expFault, input string name);
        int waited;
        resp_ready = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        waitResp(waited);
        check({name, "_lat"}, 32'(waited), 32'(LAT + 1));
        check({name, "_instr"}, resp_instr, expInstr);
        check({name, "_fault"}, 32'(resp_fault), 32'(expFault));
        @(negedge clk);
    endtask

    initial begin
        int          accepted;
        int          waited;
        int          seen;
        int          sent;
        int          got;
        int          w;
        logic [31:0] old5;
        logic [31:0] expQ [$];
        logic [31:0] e;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        // ---- Program image loaded while reset is held ----
        @(negedge clk);
        for (int i = 0; i < 256; i++) loadWord(i, fillWord(i));
        for (int i = 0; i < 4; i++) loadWord(i, img[i]);
        loadWord(4, 32'h1111_1111);
        loadWord(255, 32'hCAFE_F00D);

        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_instr", resp_instr,      32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);

        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready",  32'(req_ready),  32'd1);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);

        // ---- Table-driven single fetches ----
        vecs[0] = '{32'h0000_0000, 32'h2008_0005, 1'b0, "w0"};
        vecs[1] = '{32'h0000_0004, 32'h2009_0007, 1'b0, "w1"};
        vecs[2] = '{32'h0000_0008, 32'h0109_5020, 1'b0, "w2"};
        vecs[3] = '{32'h0000_000C, 32'hAC0A_0000, 1'b0, "w3"};
        vecs[4] = '{32'h0000_0002, 32'h0000_0000, 1'b1, "misalign2"};
        vecs[5] = '{32'h0000_0001, 32'h0000_0000, 1'b1, "misalign1"};
        vecs[6] = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b0, "last_word"};
        vecs[7] = '{32'h0000_0400, 32'h0000_0000, 1'b1, "word256"};
        vecs[8] = '{32'h8000_0000, 32'h0000_0000, 1'b1, "high_addr"};
        for (int i = 0; i < 9; i++) begin
            fetchOne(vecs[i].addr, vecs[i].instr, vecs[i].fault, vecs[i].name);
        end

        // ---- Back-to-back fetches 0,4,8,C ----
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_ready", 32'(req_ready), 32'd1);
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            @(negedge clk);
            // Accept of word 0 at edge N: first response visible after N+3.
            check("b2b_first_valid", 32'(resp_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", 32'(resp_valid), 32'd1);
            check("b2b_instr", resp_instr, img[i]);
            check("b2b_fault", 32'(resp_fault), 32'd0);
            @(negedge clk);
        end
        check("b2b_drained", 32'(resp_valid), 32'd0);

        // ---- Backpressure: 6 offered, 4 accepted ----
        resp_ready = 1'b0;
        accepted   = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            if (req_ready) accepted++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("bp_valid", 32'(resp_valid), 32'd1);
        check("bp_hold_instr", resp_instr, img[0]);
        check("bp_still_full", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_instr", resp_instr, img[k]);
            @(negedge clk);
            if (k == 0) check("bp_ready_after_pop", 32'(req_ready), 32'd1);
        end
        check("bp_drained", 32'(resp_valid), 32'd0);

        // ---- Same-cycle fetch and load: read-before-write ----
        req_valid = 1'b1;
        req_addr  = 32'h0000_0010;
        load_en   = 1'b1;
        load_addr = ADDR_BITS'(4);
        load_data = 32'hDEAD_BEEF;
        tbMem[4]  = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        load_en   = 1'b0;
        waitResp(waited);
        check("rbw_old", resp_instr, 32'h1111_1111);
        @(negedge clk);
        fetchOne(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "rbw_new");

        // ---- Load after accept does not disturb the word in flight ----
        old5      = tbMem[5];
        req_valid = 1'b1;
        req_addr  = 32'h0000_0014;
        @(negedge clk);
        req_valid = 1'b0;
        loadWord(5, 32'h5555_AAAA);
        waitResp(waited);
        check("inflight_old", resp_instr, old5);
        @(negedge clk);

        // ---- Reset with two requests in flight ----
        req_valid = 1'b1;
        req_addr  = 32'h0000_0004;
        @(negedge clk);
        req_addr  = 32'h0000_0008;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("midrst_req_ready",  32'(req_ready),  32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        fetchOne(32'h0000_0000, 32'h2008_0005, 1'b0, "post_rst");

        // ---- Continuous random fetches, resp_ready toggling ----
        sent = 0;
        got  = 0;
        resp_ready = 1'b0;
        w = 0;
        for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
            resp_ready = ~resp_ready;
            req_valid  = (sent < 100);
            if (req_valid) begin
                w = int'($urandom_range(0, 255));
                req_addr = 32'(w) << 2;
            end
            if (req_valid && req_ready) begin
                expQ.push_back(tbMem[w]);
                sent++;
            end
            if (resp_valid && resp_ready) begin
                if (expQ.size() == 0) begin
                    check("rand_extra_resp", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("rand_instr", resp_instr, e);
                    check("rand_fault", 32'(resp_fault), 32'd0);
                end
                got++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("rand_got", 32'(got), 32'd100);
        check("rand_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
